// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug response scheduler.
//   src_e        : response source index (status, read, write, time)
//   state_e      : message emitter FSM states
//   PREFIX_TABLE : first message character per source
//   MSG_LEN      : bytes per message (prefix, 8 hex digits, CR, LF)
package dbg_pkg;

    localparam int unsigned NUM_SRC   = 4;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned NIBBLES   = PAYLOAD_W / 4;
    localparam int unsigned MSG_LEN   = 11;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DROP_W    = 8;

    typedef enum logic [SRC_W-1:0] {
        SRC_STATUS = 2'd0,
        SRC_READ   = 2'd1,
        SRC_WRITE  = 2'd2,
        SRC_TIME   = 2'd3
    } src_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_GAP    = 3'd5
    } state_e;

    // Index by src_e: 'S', 'R', 'W', 'T'.
    localparam logic [NUM_SRC-1:0][BYTE_W-1:0] PREFIX_TABLE = {8'h54, 8'h57, 8'h52, 8'h53};

    localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

    function automatic logic [BYTE_W-1:0] prefix_char(input src_e src);
        return PREFIX_TABLE[src];
    endfunction

endpackage

// File: rtl/dbg_hex_nibble.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
//   nibble_i : value 0..15
//   ascii_o  : '0'..'9' or 'A'..'F'
module dbg_hex_nibble (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // 0x37 + 10 = 'A'
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/dbg_resp_sched.sv
// Debug response scheduler: collects per-source response requests, grants
// them round-robin and serialises each as an 11-byte ASCII message
// ("<prefix><8 hex digits>\r\n") into a byte-strobe UART transmitter.
//   clk_i, rst_ni  : clock, async active-low reset
//   req_i          : per-source request pulses [0]S [1]R [2]W [3]T
//   payload_i      : per-source 32-bit payload, latched with req_i
//   tx_stb_o       : one-cycle byte strobe to the transmitter
//   tx_data_o      : byte accompanying tx_stb_o, held until the next strobe
//   tx_busy_i      : transmitter busy
//   pending_o      : per-source pending flags
//   busy_o         : message in progress
//   drop_cnt_o     : saturating count of overwritten requests
module dbg_resp_sched
    import dbg_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_SRC-1:0]                  req_i,
    input  logic [NUM_SRC-1:0][PAYLOAD_W-1:0]   payload_i,
    output logic                                tx_stb_o,
    output logic [BYTE_W-1:0]                   tx_data_o,
    input  logic                                tx_busy_i,
    output logic [NUM_SRC-1:0]                  pending_o,
    output logic                                busy_o,
    output logic [DROP_W-1:0]                   drop_cnt_o
);

    localparam int unsigned DROPN_W = 3;
    localparam int unsigned GAP_W   = 32;

    state_e                             r_state;
    logic [NUM_SRC-1:0]                 r_pending;
    logic [NUM_SRC-1:0][PAYLOAD_W-1:0]  r_payload;
    logic [PAYLOAD_W-1:0]               r_msg;
    src_e                               r_src;
    src_e                               r_last;
    logic [IDX_W-1:0]                   r_idx;
    logic [GAP_W-1:0]                   r_gap_cnt;
    logic                               r_stb;
    logic [BYTE_W-1:0]                  r_data;
    logic                               r_busy;
    logic [DROP_W-1:0]                  r_drop;

    logic                               w_grant;
    logic                               w_found;
    logic [SRC_W-1:0]                   w_cand;
    src_e                               w_grant_src;
    logic [NUM_SRC-1:0]                 w_grant_mask;
    logic [NUM_SRC-1:0]                 w_drop_vec;
    logic [DROPN_W-1:0]                 w_drop_num;
    logic [DROP_W:0]                    w_drop_sum;
    logic [DROP_W-1:0]                  w_drop_next;
    logic [BYTE_W-1:0]                  w_hex;
    logic [BYTE_W-1:0]                  w_byte;
    logic                               w_is_digit;

    // Round-robin pick: first pending source after the last granted one.
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        w_grant_src = r_last;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_cand = r_last + SRC_W'(k);
            if (!w_found && r_pending[w_cand]) begin
                w_found     = 1'b1;
                w_grant_src = src_e'(w_cand);
            end
        end
    end

    assign w_grant      = (r_state == ST_IDLE) && (|r_pending);
    assign w_grant_mask = w_grant ? (NUM_SRC'(1) << w_grant_src) : '0;

    // A request on the granted source in its grant cycle is a fresh request, not a drop.
    assign w_drop_vec = req_i & r_pending & ~w_grant_mask;

    always_comb begin
        w_drop_num = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_drop_num = w_drop_num + DROPN_W'(w_drop_vec[i]);
        end
        w_drop_sum  = (DROP_W+1)'(r_drop) + (DROP_W+1)'(w_drop_num);
        w_drop_next = (w_drop_sum > (DROP_W+1)'(255)) ? 8'hFF : w_drop_sum[DROP_W-1:0];
    end

    // Pending flags, payload capture and drop counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_payload <= '0;
            r_drop    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_mask) | req_i;
            r_drop    <= w_drop_next;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (req_i[i]) begin
                    r_payload[i] <= payload_i[i];
                end
            end
        end
    end

    dbg_hex_nibble u_hex (
        .nibble_i (r_msg[PAYLOAD_W-1 -: 4]),
        .ascii_o  (w_hex)
    );

    // Byte for the current index; digits come from the top nibble of the shifter.
    always_comb begin
        w_byte = w_hex;
        if (r_idx == '0) begin
            w_byte = prefix_char(r_src);
        end else if (r_idx == IDX_W'(MSG_LEN - 2)) begin
            w_byte = CHAR_CR;
        end else if (r_idx == IDX_W'(MSG_LEN - 1)) begin
            w_byte = CHAR_LF;
        end
    end

    assign w_is_digit = (r_idx != '0) && (r_idx <= IDX_W'(NIBBLES));

    // Message emitter FSM with registered strobe, data and busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_msg     <= '0;
            r_src     <= SRC_STATUS;
            r_last    <= SRC_TIME;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_stb     <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_msg   <= r_payload[w_grant_src];
                        r_src   <= w_grant_src;
                        r_last  <= w_grant_src;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy_i) begin
                        r_stb  <= 1'b1;
                        r_data <= w_byte;
                        if (w_is_digit) begin
                            r_msg <= r_msg << 4;
                        end
                        r_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    r_state <= ST_HOLD;
                end
                // Gives the transmitter a cycle to raise busy before it is sampled.
                ST_HOLD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy_i) begin
                        if (r_idx == IDX_W'(MSG_LEN - 1)) begin
                            r_idx <= '0;
                            if (GAP_CYCLES == 0) begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                                r_state   <= ST_GAP;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_stb_o   = r_stb;
    assign tx_data_o  = r_data;
    assign pending_o  = r_pending;
    assign busy_o     = r_busy;
    assign drop_cnt_o = r_drop;

    // Strobes are always isolated single-cycle pulses.
    a_stb_single: assert property (@(posedge clk_i) disable iff (!rst_ni) tx_stb_o |=> !tx_stb_o);
    a_clk_hz:     assert property (@(posedge clk_i) CLK_HZ != 0);

endmodule

// File: doc/dbg_resp_sched.md
DBG_RESP_SCHED -- requirements
Module: dbg_resp_sched

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency; used only by the bench and assertions.
REQ-002 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between consecutive messages.
REQ-003 SHALL have port clk_i  input  1  the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_i  input  4  per-source response request pulses: [0] status, [1] read, [2] write, [3] time.
REQ-006 SHALL have port payload_i  input  4x32  per-source 32-bit payload, sampled when the matching req_i bit is high.
REQ-007 SHALL have port tx_stb_o  output  1  one-cycle byte strobe to the UART transmitter.
REQ-008 SHALL have port tx_data_o  output  8  byte that accompanies tx_stb_o.
REQ-009 SHALL have port tx_busy_i  input  1  UART transmitter busy; it rises no later than 1 cycle after tx_stb_o.
REQ-010 SHALL have port pending_o  output  4  per-source pending flags.
REQ-011 SHALL have port busy_o  output  1  high while a message is being emitted.
REQ-012 SHALL have port drop_cnt_o  output  8  saturating count of overwritten requests.

Function
REQ-013 SHALL set pending[i] and latch payload_i[i] into a per-source register on each cycle where req_i[i]=1.
REQ-014 SHALL, when req_i[i] arrives while pending[i]=1, overwrite the payload, keep pending set, and increment drop_cnt_o (saturating at 255).
REQ-015 SHALL, in IDLE with any pending bit set, grant round-robin: the first pending source after the last granted source, wrapping 3->0; after reset the last granted source is 3, so source 0 has first priority.
REQ-016 SHALL, on grant, copy the granted payload into a message shift register and clear that pending bit in the same cycle.
REQ-017 SHALL record a req_i arriving on the grant cycle for the granted source as a new pending request; this does not count as a drop.
REQ-018 SHALL emit 11 bytes per message, in order: the prefix ('S','R','W','T' for sources 0..3), 8 uppercase ASCII hex digits MSB-nibble first, 0x0D, 0x0A.
REQ-019 SHALL use the FSM states IDLE, LOAD, STROBE, HOLD, WAIT, GAP:
- IDLE->LOAD when any bit is pending.
- LOAD->STROBE when tx_busy_i=0.
- STROBE: tx_stb_o=1 for exactly one cycle, then ->HOLD.
- HOLD lasts 1 cycle, then ->WAIT.
- WAIT->LOAD (next byte) when tx_busy_i=0, or ->GAP after byte 11.
- GAP lasts GAP_CYCLES cycles, then ->IDLE.
REQ-020 SHALL never assert tx_stb_o while tx_busy_i=1 or on two consecutive cycles.
REQ-021 SHALL hold tx_data_o stable from the STROBE cycle until the next STROBE.
REQ-022 SHALL hold busy_o high from the LOAD state of the first byte through the WAIT or GAP state of the last byte.
REQ-023 SHALL complete a message without preemption; requests arriving during a message only set pending bits.
REQ-024 SHALL, with GAP_CYCLES=0, make a pending request visible in IDLE on the cycle after the last WAIT.

Reset
REQ-025 SHALL, on rst_ni=0 at any time including mid-message, clear to IDLE immediately:
- tx_stb_o=0, tx_data_o=0x00, busy_o=0.
- pending_o=0, drop_cnt_o=0.
- last granted source=3, byte index=0.
REQ-026 SHALL, after rst_ni deasserts, issue no tx_stb_o before a new req_i.

Structure
REQ-027 SHALL place the source-index enum, the prefix-character table, MSG_LEN=11 and the FSM state typedef in package dbg_pkg.
REQ-028 SHALL use one sub-module, dbg_hex_nibble, a combinational 4-bit to ASCII hex converter.
REQ-029 SHALL be 120-400 lines of RTL.

Verification
REQ-030 Status test: req_i=0001 with payload 0x0000_00A5 -> UART bytes "S000000A5"\r\n; busy_o then falls and pending_o=0.
REQ-031 Simultaneous requests: req_i=1111 in one cycle with distinct payloads -> messages in order S,R,W,T; pending_o decrements one bit per grant.
REQ-032 Overwrite: two read requests 0x11111111 then 0x89ABCDEF while source 0 is sending -> a single "R89ABCDEF" and drop_cnt_o=1; 300 extra requests -> drop_cnt_o=255.
REQ-033 Back-pressure: tx_busy_i held high for 5000 cycles after each strobe -> no tx_stb_o during busy; never two strobes closer than 2 cycles; byte order intact.
REQ-034 Reset mid-message: rst_ni low after byte 4 -> tx_stb_o stays 0 and all outputs return to reset values; the next req_i produces a complete 11-byte message.
REQ-035 Round-robin fairness: the time source re-requested every message while the others request once -> T does not starve the others; grant order follows the wrap rule.
